// File: rtl/stream_fifo_pkg.sv
// Shared helpers for stream_fifo: width calculations and parameter legality.
package stream_fifo_pkg;

  // Pointer width: indexes DEPTH entries and wraps modulo DEPTH.
  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Occupancy width: must represent 0..DEPTH inclusive.
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic bit is_pow2(input int v);
    return (v > 0) && ((v & (v - 1)) == 0);
  endfunction

  // True when the parameter set describes a buildable FIFO.
  function automatic bit params_ok(input int dw, input int depth,
                                   input int af, input int ae);
    return (dw >= 1) && is_pow2(depth) && (depth >= 4) &&
           (af >= 1) && (af <= depth) && (ae >= 0) && (ae < depth);
  endfunction

endpackage

// File: rtl/stream_fifo_ram.sv
// Simple dual-port RAM: synchronous write, synchronous read (read-first on
// an address collision). Contents are not reset.
module stream_fifo_ram #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 32,
  parameter int AW         = 5
) (
  input  logic                  clk,
  input  logic                  we_i,
  input  logic [AW-1:0]         waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]         raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_q;

  // Write when enabled; read every cycle so the head word is always prefetched.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/stream_fifo.sv
// First-word-fall-through FIFO with a registered output stage.
// The output register holds the head word; the RAM holds the rest.
// count covers both. Optional macro STREAM_FIFO_HWM_EN adds a high-water
// mark output (hwm).
module stream_fifo
  import stream_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 32,
  parameter int AF_LEVEL   = 28,
  parameter int AE_LEVEL   = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic                         s_valid,
  input  logic [DATA_WIDTH-1:0]        s_data,
  output logic                         s_ready,
  output logic                         m_valid,
  output logic [DATA_WIDTH-1:0]        m_data,
  input  logic                         m_ready,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         almost_full,
`ifdef STREAM_FIFO_HWM_EN
  output logic [$clog2(DEPTH+1)-1:0]   hwm,
`endif
  output logic                         almost_empty
);

  localparam int AW = ptr_w(DEPTH);
  localparam int CW = cnt_w(DEPTH);

  if (!params_ok(DATA_WIDTH, DEPTH, AF_LEVEL, AE_LEVEL)) begin : g_bad_params
    $error("stream_fifo: illegal parameter set");
  end

  // Handshake: a transfer happens only on valid && ready at a rising edge;
  // s_ready is a flop (no m_ready -> s_ready path), illegal requests are ignored.

  logic [AW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d, ram_cnt;
  logic                  m_valid_q, m_valid_d;
  logic [DATA_WIDTH-1:0] m_data_q, m_data_d;
  logic                  s_ready_q, af_q, ae_q;
  logic                  byp_sel_q, byp_sel_d;
  logic [DATA_WIDTH-1:0] byp_q;
  logic [DATA_WIDTH-1:0] ram_rdata, head_data;
  logic                  push, pop, ram_empty, to_out, ram_we, ram_re;

  // Next-state for pointers, count and the output register.
  always_comb begin
    push      = s_valid && s_ready_q;
    pop       = m_valid_q && m_ready;
    ram_cnt   = count_q - CW'(m_valid_q);
    ram_empty = (ram_cnt == '0);
    // Incoming word skips the RAM when the output stage is (or becomes) free
    // and nothing older is queued behind it.
    to_out    = push && ram_empty && (!m_valid_q || pop);
    ram_we    = push && !to_out && !flush;
    ram_re    = pop && !ram_empty;
    // A word written into the RAM on the same edge it became head is not yet
    // visible on the read port; serve it from the bypass copy for one cycle.
    head_data = byp_sel_q ? byp_q : ram_rdata;

    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;

    if (ram_we) wr_ptr_d = wr_ptr_q + 1'b1;
    if (ram_re) rd_ptr_d = rd_ptr_q + 1'b1;

    if (ram_re)      m_data_d = head_data;
    else if (to_out) m_data_d = s_data;
    if (pop || to_out) m_valid_d = ram_re || to_out;

    if (push && !pop)      count_d = count_q + 1'b1;
    else if (pop && !push) count_d = count_q - 1'b1;

    if (flush) begin
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      count_d   = '0;
      m_valid_d = 1'b0;
      m_data_d  = '0;
    end

    byp_sel_d = ram_we && (wr_ptr_q == rd_ptr_d);
  end

  // State registers; flags and s_ready follow next-count so they track count exactly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      s_ready_q <= 1'b1;
      af_q      <= 1'b0;
      ae_q      <= 1'b1;
      byp_sel_q <= 1'b0;
      byp_q     <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
      s_ready_q <= (count_d != CW'(DEPTH));
      af_q      <= (count_d >= CW'(AF_LEVEL));
      ae_q      <= (count_d <= CW'(AE_LEVEL));
      byp_sel_q <= byp_sel_d;
      byp_q     <= s_data;
    end
  end

  stream_fifo_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .AW         (AW)
  ) u_ram (
    .clk     (clk),
    .we_i    (ram_we),
    .waddr_i (wr_ptr_q),
    .wdata_i (s_data),
    .raddr_i (rd_ptr_d),
    .rdata_o (ram_rdata)
  );

`ifdef STREAM_FIFO_HWM_EN
  logic [CW-1:0] hwm_q;

  // High-water mark: running maximum of count, cleared by reset and flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 hwm_q <= '0;
    else if (flush)             hwm_q <= '0;
    else if (count_d > hwm_q)   hwm_q <= count_d;
  end

  assign hwm = hwm_q;
`endif

  assign s_ready      = s_ready_q;
  assign m_valid      = m_valid_q;
  assign m_data       = m_data_q;
  assign count        = count_q;
  assign almost_full  = af_q;
  assign almost_empty = ae_q;

endmodule

// File: tb/tb_stream_fifo.sv
// Bench for stream_fifo (default parameters, optional STREAM_FIFO_HWM_EN).
module tb_stream_fifo;

  localparam int DW    = 8;
  localparam int DEPTH = 32;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          flush = 1'b0;
  logic          s_valid = 1'b0;
  logic [DW-1:0] s_data = '0;
  logic          s_ready;
  logic          m_valid;
  logic [DW-1:0] m_data;
  logic          m_ready = 1'b0;
  logic [CW-1:0] count;
  logic          almost_full;
  logic          almost_empty;
`ifdef STREAM_FIFO_HWM_EN
  logic [CW-1:0] hwm;
`endif

  int checks = 0;
  int errors = 0;

  // Scoreboard: expected contents, head first.
  logic [DW-1:0] exp_q[$];
  int            mhwm = 0;

  typedef struct {
    logic          fl;
    logic          sv;
    logic [DW-1:0] d;
    logic          mr;
    int            cnt;
    logic          mv;
    logic          cd;
    logic [DW-1:0] md;
    logic          sr;
    logic          ae;
  } vec_t;

  vec_t vecs [12];

  stream_fifo #(
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH),
    .AF_LEVEL   (28),
    .AE_LEVEL   (4)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (flush),
    .s_valid      (s_valid),
    .s_data       (s_data),
    .s_ready      (s_ready),
    .m_valid      (m_valid),
    .m_data       (m_data),
    .m_ready      (m_ready),
    .count        (count),
    .almost_full  (almost_full),
`ifdef STREAM_FIFO_HWM_EN
    .hwm          (hwm),
`endif
    .almost_empty (almost_empty)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive one cycle: set inputs, advance the scoreboard, sample 1 time unit after the edge.
  task automatic drive_cycle(input logic fl, input logic sv, input logic [DW-1:0] d,
                             input logic mr);
    bit rdy, val;
    flush = fl; s_valid = sv; s_data = d; m_ready = mr;
    rdy = (exp_q.size() != DEPTH);
    val = (exp_q.size() != 0);
    if (fl) begin
      exp_q.delete();
      mhwm = 0;
    end else begin
      if (val && mr) void'(exp_q.pop_front());
      if (sv && rdy) exp_q.push_back(d);
      if (exp_q.size() > mhwm) mhwm = exp_q.size();
    end
    @(posedge clk);
    #1;
    flush = 1'b0; s_valid = 1'b0; m_ready = 1'b0;
  endtask

  task automatic check_model();
    int n;
    n = exp_q.size();
    chk("count", 32'(count), 32'(n));
    chk("m_valid", 32'(m_valid), 32'(n != 0));
    chk("s_ready", 32'(s_ready), 32'(n != DEPTH));
    chk("almost_full", 32'(almost_full), 32'(n >= 28));
    chk("almost_empty", 32'(almost_empty), 32'(n <= 4));
    if (n != 0) chk("m_data", 32'(m_data), 32'(exp_q[0]));
`ifdef STREAM_FIFO_HWM_EN
    chk("hwm", 32'(hwm), 32'(mhwm));
`endif
  endtask

  initial begin
    // Directed vectors: inputs for one cycle, expected outputs after the edge.
    vecs[0]  = '{1'b0, 1'b1, 8'hA1, 1'b0, 1, 1'b1, 1'b1, 8'hA1, 1'b1, 1'b1};
    vecs[1]  = '{1'b0, 1'b1, 8'hB2, 1'b0, 2, 1'b1, 1'b1, 8'hA1, 1'b1, 1'b1};
    vecs[2]  = '{1'b0, 1'b1, 8'hC3, 1'b1, 2, 1'b1, 1'b1, 8'hB2, 1'b1, 1'b1};
    vecs[3]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1, 1'b1, 1'b1, 8'hC3, 1'b1, 1'b1};
    vecs[4]  = '{1'b0, 1'b1, 8'hD4, 1'b1, 1, 1'b1, 1'b1, 8'hD4, 1'b1, 1'b1};
    vecs[5]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1, 1'b1, 1'b1, 8'hD4, 1'b1, 1'b1};
    vecs[6]  = '{1'b0, 1'b0, 8'h00, 1'b1, 0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1};
    vecs[7]  = '{1'b0, 1'b0, 8'h00, 1'b1, 0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1};
    vecs[8]  = '{1'b0, 1'b1, 8'hE5, 1'b0, 1, 1'b1, 1'b1, 8'hE5, 1'b1, 1'b1};
    vecs[9]  = '{1'b1, 1'b1, 8'hF6, 1'b0, 0, 1'b0, 1'b1, 8'h00, 1'b1, 1'b1};
    vecs[10] = '{1'b0, 1'b1, 8'h17, 1'b0, 1, 1'b1, 1'b1, 8'h17, 1'b1, 1'b1};
    vecs[11] = '{1'b0, 1'b0, 8'h00, 1'b1, 0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1};

    // Reset
    repeat (3) @(posedge clk);
    #1;
    chk("rst_count_async", 32'(count), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_s_ready", 32'(s_ready), 32'd1);
    chk("rst_m_valid", 32'(m_valid), 32'd0);
    chk("rst_m_data", 32'(m_data), 32'd0);
    chk("rst_almost_full", 32'(almost_full), 32'd0);
    chk("rst_almost_empty", 32'(almost_empty), 32'd1);
`ifdef STREAM_FIFO_HWM_EN
    chk("rst_hwm", 32'(hwm), 32'd0);
`endif

    // Table-driven vectors
    for (int i = 0; i < 12; i++) begin
      drive_cycle(vecs[i].fl, vecs[i].sv, vecs[i].d, vecs[i].mr);
      chk($sformatf("vec%0d_count", i), 32'(count), 32'(vecs[i].cnt));
      chk($sformatf("vec%0d_m_valid", i), 32'(m_valid), 32'(vecs[i].mv));
      if (vecs[i].cd) chk($sformatf("vec%0d_m_data", i), 32'(m_data), 32'(vecs[i].md));
      chk($sformatf("vec%0d_s_ready", i), 32'(s_ready), 32'(vecs[i].sr));
      chk($sformatf("vec%0d_almost_empty", i), 32'(almost_empty), 32'(vecs[i].ae));
      chk($sformatf("vec%0d_almost_full", i), 32'(almost_full), 32'd0);
    end
    check_model();

    // Fill 0x00..0x1F without popping
    for (int i = 0; i < DEPTH; i++) begin
      drive_cycle(1'b0, 1'b1, 8'(i), 1'b0);
      check_model();
      chk("fill_af", 32'(almost_full), 32'(i + 1 >= 28));
    end
    chk("full_count", 32'(count), 32'd32);
    chk("full_s_ready", 32'(s_ready), 32'd0);
    drive_cycle(1'b0, 1'b1, 8'h99, 1'b0);
    check_model();

    // Drain in order
    for (int i = 0; i < DEPTH; i++) begin
      chk("drain_order", 32'(m_data), 32'(i));
      drive_cycle(1'b0, 1'b0, 8'h00, 1'b1);
      check_model();
    end
    chk("drained_m_valid", 32'(m_valid), 32'd0);
    chk("drained_almost_empty", 32'(almost_empty), 32'd1);

    // Continuous stream across pointer wrap
    drive_cycle(1'b0, 1'b1, 8'h40, 1'b0);
    for (int i = 1; i <= 100; i++) begin
      drive_cycle(1'b0, 1'b1, 8'(8'h40 + i), 1'b1);
      chk("stream_count", 32'(count), 32'd1);
      chk("stream_data", 32'(m_data), 32'(8'(8'h40 + i)));
    end
    drive_cycle(1'b0, 1'b0, 8'h00, 1'b1);
    check_model();

    // Pop while full with s_valid: push rejected
    for (int i = 0; i < DEPTH; i++) drive_cycle(1'b0, 1'b1, 8'(8'h80 + i), 1'b0);
    check_model();
    drive_cycle(1'b0, 1'b1, 8'hAA, 1'b1);
    chk("fullpop_count", 32'(count), 32'd31);
    chk("fullpop_s_ready", 32'(s_ready), 32'd1);
    chk("fullpop_m_data", 32'(m_data), 32'h81);
    while (exp_q.size() != 0) begin
      drive_cycle(1'b0, 1'b0, 8'h00, 1'b1);
      check_model();
    end

    // Flush with concurrent s_valid at count 10
    for (int i = 0; i < 10; i++) drive_cycle(1'b0, 1'b1, 8'(8'h20 + i), 1'b0);
    chk("pre_flush_count", 32'(count), 32'd10);
    drive_cycle(1'b1, 1'b1, 8'hEE, 1'b0);
    chk("flush_count", 32'(count), 32'd0);
    chk("flush_m_valid", 32'(m_valid), 32'd0);
    chk("flush_m_data", 32'(m_data), 32'd0);
    check_model();
    drive_cycle(1'b0, 1'b1, 8'h51, 1'b0);
    drive_cycle(1'b0, 1'b1, 8'h52, 1'b0);
    chk("post_flush_head", 32'(m_data), 32'h51);
    for (int i = 0; i < 3; i++) begin
      drive_cycle(1'b0, 1'b0, 8'h00, 1'b1);
      check_model();
    end

    // Hold under backpressure
    drive_cycle(1'b0, 1'b1, 8'h3C, 1'b0);
    drive_cycle(1'b0, 1'b1, 8'h3D, 1'b0);
    drive_cycle(1'b0, 1'b1, 8'h3E, 1'b0);
    for (int i = 0; i < 5; i++) begin
      drive_cycle(1'b0, 1'b0, 8'h00, 1'b0);
      chk("hold_data", 32'(m_data), 32'h3C);
      chk("hold_valid", 32'(m_valid), 32'd1);
    end

    // Randomised backpressure: producer-heavy, then consumer-heavy phases
    for (int i = 0; i < 600; i++) begin
      logic fl, sv, mr;
      fl = ($urandom_range(0, 79) == 0);
      if (i < 300) begin
        sv = ($urandom_range(0, 3) != 0);
        mr = ($urandom_range(0, 2) == 0);
      end else begin
        sv = ($urandom_range(0, 2) == 0);
        mr = ($urandom_range(0, 3) != 0);
      end
      drive_cycle(fl, sv, 8'($urandom_range(0, 255)), mr);
      check_model();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
